// File: rtl/arm_ctrl_pkg.sv
// Shared encodings for the multicycle ARM controller: state codes, opcodes,
// datapath mux selects and the packed control word driven by the main FSM.
package arm_ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        EXECR   = 4'd6,
        EXECI   = 4'd7,
        ALUWB   = 4'd8,
        BRANCH  = 4'd9,
        UNKNOWN = 4'd10
    } state_t;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;

    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    typedef struct packed {
        logic       ir_write;
        logic       adr_src;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] result_src;
        logic       next_pc;
        logic       reg_w;
        logic       mem_w;
        logic       branch;
        logic       alu_op;
    } ctrl_t;

endpackage

// File: rtl/arm_main_fsm_outdec.sv
// Combinational state -> control-word decoder for the main FSM (Moore outputs).
module arm_main_fsm_outdec
    import arm_ctrl_pkg::*;
(
    input  state_t state,
    output ctrl_t  ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            FETCH: begin
                ctrl.ir_write   = 1'b1;
                ctrl.next_pc    = 1'b1;
                ctrl.alu_src_a  = 1'b1;
                ctrl.alu_src_b  = SRCB_FOUR;
                ctrl.result_src = RES_ALURESULT;
            end
            DECODE: begin
                ctrl.alu_src_a  = 1'b1;
                ctrl.alu_src_b  = SRCB_FOUR;
                ctrl.result_src = RES_ALURESULT;
            end
            MEMADR: ctrl.alu_src_b = SRCB_IMM;
            MEMRD: begin
                ctrl.adr_src    = 1'b1;
                ctrl.result_src = RES_ALUOUT;
            end
            MEMWB: begin
                ctrl.result_src = RES_DATA;
                ctrl.reg_w      = 1'b1;
            end
            MEMWR: begin
                ctrl.adr_src    = 1'b1;
                ctrl.result_src = RES_ALUOUT;
                ctrl.mem_w      = 1'b1;
            end
            EXECR: begin
                ctrl.alu_src_b = SRCB_REG;
                ctrl.alu_op    = 1'b1;
            end
            EXECI: begin
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = 1'b1;
            end
            ALUWB: begin
                ctrl.result_src = RES_ALUOUT;
                ctrl.reg_w      = 1'b1;
            end
            BRANCH: begin
                ctrl.alu_src_b  = SRCB_IMM;
                ctrl.result_src = RES_ALURESULT;
                ctrl.branch     = 1'b1;
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/arm_main_fsm.sv
// Multicycle ARM main control FSM (fetch/decode/execute/memory/writeback).
// Optional ARM_MAIN_FSM_MEM_WAIT_EN adds a MemReady handshake in FETCH/MEMRD/MEMWR.
module arm_main_fsm
    import arm_ctrl_pkg::*;
#(
    parameter int STATE_W = 4
)
(
    input  logic               clk,
    input  logic               reset,
    input  logic [1:0]         Op,
    input  logic [5:0]         Funct,
`ifdef ARM_MAIN_FSM_MEM_WAIT_EN
    input  logic               MemReady,
`endif
    output logic               IRWrite,
    output logic               AdrSrc,
    output logic               ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [1:0]         ResultSrc,
    output logic               NextPC,
    output logic               RegW,
    output logic               MemW,
    output logic               Branch,
    output logic               ALUOp,
    output logic               Illegal,
    output logic [STATE_W-1:0] State
);

    state_t state;
    state_t next_state;
    ctrl_t  decoded;
    ctrl_t  ctrl;
    logic   mem_ready;
    logic   illegal;
    logic   unused_funct;

`ifdef ARM_MAIN_FSM_MEM_WAIT_EN
    assign mem_ready = MemReady;
`else
    assign mem_ready = 1'b1;
`endif

    // Only the I bit and L/S bit steer the sequence; the rest belong to the ALU decoder.
    assign unused_funct = ^Funct[4:1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= FETCH;
            illegal <= 1'b0;
        end else begin
            state <= next_state;
            if (state == UNKNOWN)
                illegal <= 1'b1;
        end
    end

    always_comb begin
        next_state = FETCH;
        case (state)
            FETCH:  next_state = mem_ready ? DECODE : FETCH;
            DECODE: begin
                case (Op)
                    OP_DP:   next_state = Funct[5] ? EXECI : EXECR;
                    OP_MEM:  next_state = MEMADR;
                    OP_BR:   next_state = BRANCH;
                    default: next_state = UNKNOWN;
                endcase
            end
            MEMADR:  next_state = Funct[0] ? MEMRD : MEMWR;
            MEMRD:   next_state = mem_ready ? MEMWB : MEMRD;
            MEMWB:   next_state = FETCH;
            MEMWR:   next_state = mem_ready ? FETCH : MEMWR;
            EXECR:   next_state = ALUWB;
            EXECI:   next_state = ALUWB;
            ALUWB:   next_state = FETCH;
            BRANCH:  next_state = FETCH;
            UNKNOWN: next_state = FETCH;
            default: next_state = FETCH;
        endcase
    end

    arm_main_fsm_outdec u_outdec (
        .state (state),
        .ctrl  (decoded)
    );

    // A stalled fetch must not latch the instruction or advance the PC.
    always_comb begin
        ctrl = decoded;
        if (state == FETCH && !mem_ready) begin
            ctrl.ir_write = 1'b0;
            ctrl.next_pc  = 1'b0;
        end
    end

    assign IRWrite   = ctrl.ir_write;
    assign AdrSrc    = ctrl.adr_src;
    assign ALUSrcA   = ctrl.alu_src_a;
    assign ALUSrcB   = ctrl.alu_src_b;
    assign ResultSrc = ctrl.result_src;
    assign NextPC    = ctrl.next_pc;
    assign RegW      = ctrl.reg_w;
    assign MemW      = ctrl.mem_w;
    assign Branch    = ctrl.branch;
    assign ALUOp     = ctrl.alu_op;
    assign Illegal   = illegal;
    assign State     = STATE_W'(state);

endmodule

// File: tb/tb_arm_main_fsm.sv
// Scoreboard bench for arm_main_fsm: expected state/Illegal pushed per instruction,
// popped and compared (with the per-state output table) one cycle at a time.
module tb_arm_main_fsm;

    logic       clk;
    logic       reset;
    logic [1:0] Op;
    logic [5:0] Funct;
`ifdef ARM_MAIN_FSM_MEM_WAIT_EN
    logic       MemReady;
`endif
    logic       IRWrite;
    logic       AdrSrc;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ResultSrc;
    logic       NextPC;
    logic       RegW;
    logic       MemW;
    logic       Branch;
    logic       ALUOp;
    logic       Illegal;
    logic [3:0] State;

    typedef struct {
        int st;
        bit ill;
        bit mr;
    } exp_t;

    exp_t scoreboard[$];
    int   checks   = 0;
    int   failures = 0;
    bit   modelIllegal = 1'b0;

    arm_main_fsm #(.STATE_W(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .Op        (Op),
        .Funct     (Funct),
`ifdef ARM_MAIN_FSM_MEM_WAIT_EN
        .MemReady  (MemReady),
`endif
        .IRWrite   (IRWrite),
        .AdrSrc    (AdrSrc),
        .ALUSrcA   (ALUSrcA),
        .ALUSrcB   (ALUSrcB),
        .ResultSrc (ResultSrc),
        .NextPC    (NextPC),
        .RegW      (RegW),
        .MemW      (MemW),
        .Branch    (Branch),
        .ALUOp     (ALUOp),
        .Illegal   (Illegal),
        .State     (State)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Output table {IRWrite,AdrSrc,ALUSrcA,ALUSrcB,ResultSrc,NextPC,RegW,MemW,Branch,ALUOp}.
    function automatic logic [11:0] expOut(input int st, input bit mr);
        logic       ir, adr, sa, npc, rw, mw, br, aop;
        logic [1:0] sb, rs;
        {ir, adr, sa, npc, rw, mw, br, aop} = 8'b0;
        sb = 2'b00;
        rs = 2'b00;
        case (st)
            0:  begin ir = mr; npc = mr; sa = 1'b1; sb = 2'b10; rs = 2'b10; end
            1:  begin sa = 1'b1; sb = 2'b10; rs = 2'b10; end
            2:  begin sb = 2'b01; end
            3:  begin adr = 1'b1; end
            4:  begin rs = 2'b01; rw = 1'b1; end
            5:  begin adr = 1'b1; mw = 1'b1; end
            6:  begin aop = 1'b1; end
            7:  begin sb = 2'b01; aop = 1'b1; end
            8:  begin rw = 1'b1; end
            9:  begin sb = 2'b01; rs = 2'b10; br = 1'b1; end
            default: ;
        endcase
        return {ir, adr, sa, sb, rs, npc, rw, mw, br, aop};
    endfunction

    task automatic pushState(input int st, input bit mr);
        exp_t e;
        e.st  = st;
        e.ill = modelIllegal;
        e.mr  = mr;
        scoreboard.push_back(e);
    endtask

    task automatic applyStimulus(input logic [1:0] op, input logic [5:0] funct);
        Op    = op;
        Funct = funct;
        pushState(0, 1'b1);
        pushState(1, 1'b1);
        case (op)
            2'b00: begin pushState(funct[5] ? 7 : 6, 1'b1); pushState(8, 1'b1); end
            2'b01: begin
                pushState(2, 1'b1);
                if (funct[0]) begin pushState(3, 1'b1); pushState(4, 1'b1); end
                else pushState(5, 1'b1);
            end
            2'b10: pushState(9, 1'b1);
            default: begin pushState(10, 1'b1); modelIllegal = 1'b1; end
        endcase
    endtask

    task automatic checkOutput(input exp_t e);
        logic [11:0] obs;
        logic [11:0] req;
        obs = {IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, NextPC, RegW, MemW, Branch, ALUOp};
        req = expOut(e.st, e.mr);
        checks++;
        assert (State === 4'(e.st)) else begin
            failures++;
            $error("[TB] FAIL state: observed=%0d expected=%0d", State, e.st);
        end
        checks++;
        assert (Illegal === e.ill) else begin
            failures++;
            $error("[TB] FAIL illegal (state %0d): observed=%b expected=%b", e.st, Illegal, e.ill);
        end
        checks++;
        assert (obs === req) else begin
            failures++;
            $error("[TB] FAIL outputs (state %0d): observed=%b expected=%b", e.st, obs, req);
        end
    endtask

    task automatic drainQueue(input bit advanceLast);
        exp_t e;
        while (scoreboard.size() > 0) begin
            e = scoreboard.pop_front();
`ifdef ARM_MAIN_FSM_MEM_WAIT_EN
            MemReady = e.mr;
`endif
            #1;
            checkOutput(e);
            if (scoreboard.size() > 0 || advanceLast) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset = 1'b1;
        Op    = 2'b00;
        Funct = 6'b000000;
`ifdef ARM_MAIN_FSM_MEM_WAIT_EN
        MemReady = 1'b1;
`endif
        // Outputs show FETCH values while reset is held across edges.
        #10;
        pushState(0, 1'b1);
        drainQueue(1'b0);
        #8;
        pushState(0, 1'b1);
        drainQueue(1'b0);
        #2;
        reset = 1'b0;

        applyStimulus(2'b00, 6'b101000);
        drainQueue(1'b1);
        applyStimulus(2'b00, 6'b001000);
        drainQueue(1'b1);
        applyStimulus(2'b01, 6'b011001);
        drainQueue(1'b1);
        applyStimulus(2'b01, 6'b011000);
        drainQueue(1'b1);
        applyStimulus(2'b10, 6'b000000);
        drainQueue(1'b1);
        applyStimulus(2'b11, 6'b000000);
        drainQueue(1'b1);
        applyStimulus(2'b00, 6'b101000);
        drainQueue(1'b1);

`ifdef ARM_MAIN_FSM_MEM_WAIT_EN
        Op    = 2'b01;
        Funct = 6'b011000;
        pushState(0, 1'b0);
        pushState(0, 1'b1);
        pushState(1, 1'b1);
        pushState(2, 1'b1);
        pushState(5, 1'b0);
        pushState(5, 1'b0);
        pushState(5, 1'b0);
        pushState(5, 1'b1);
        drainQueue(1'b1);
`endif

        // Stop in MEMWB, then assert reset between edges: RegW must drop at once.
        applyStimulus(2'b01, 6'b011001);
        drainQueue(1'b0);
        #1;
        reset = 1'b1;
        modelIllegal = 1'b0;
        pushState(0, 1'b1);
        drainQueue(1'b0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        applyStimulus(2'b10, 6'b000000);
        drainQueue(1'b1);
        pushState(0, 1'b1);
        drainQueue(1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
